timing_generator: RTL and testbench
===================================

// Module: timing_generator
// PURPOSE
//  Upstream of the random-logic control decoder. Builds the two-phase cycle (phi1/phi2) from one clock and
//  sequences the one-hot T-state. Latches opcode (OP) and previous opcode (prevOP). Arbitrates RESET/NMI/IRQ
//  into activeInt, forcing BRK (0x00) into OP. The decoder consumes T, OP, prevOP, phi1, phi2 and activeInt.
// PARAMETERS
//  NOP_OP    8'hEA  prevOP value after reset; suppresses spurious register writeback in T2
//  BRK_OP    8'h00  opcode injected when an interrupt is taken
// PORTS
//  clk         in   1  single system clock; all state updates on rising edge
//  rst_n       in   1  synchronous, active-low reset
//  db_in       in   8  data bus; opcode byte valid at end of phi2 in Tone
//  rdy         in   1  1 = advance; 0 = hold T/OP/prevOP (phases keep toggling)
//  last_cycle  in   1  from control: current T is the instruction's final cycle
//  nmi_n       in   1  NMI request, falling-edge sensitive
//  irq_n       in   1  IRQ request, level sensitive
//  status_i    in   1  interrupt-disable flag (P.I)
//  phi1        out  1  phase 1 strobe
//  phi2        out  1  phase 2 strobe
//  T           out  7  one-hot T-state (Tone..Tseven)
//  OP          out  8  current opcode
//  prevOP      out  8  opcode of the previously completed instruction
//  activeInt   out  3  100 RESET, 010 NMI, 001 IRQ, 000 none
//  sync        out  1  high during the whole Tone cycle (opcode fetch)
//  t_err       out  1  watchdog pulse (TGEN_WATCHDOG_EN only; else constant 0)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): phi1=0, phi2=0, T=Ttwo, OP=BRK_OP, prevOP=NOP_OP, activeInt=100, sync=0,
//   t_err=0, nmi_pend=0, nmi_q=1. This starts the reset-vector sequence immediately. Reset dominates all other inputs.
//  Phase: first edge after reset release gives phi1=1. phi1/phi2 then alternate each clk. One CPU cycle = 2 clk.
//   phi1 and phi2 are never high together.
//  All sequencing decisions use inputs sampled on the edge that ends phi2 ("cycle edge"). No decisions on phi1 edges.
//  T transition at cycle edge, priority order:
//   - rdy=0: hold everything; last_cycle ignored.
//   - last_cycle=1: T<=Tone.
//   - T==Tone: T<=Ttwo; prevOP<=OP; OP<=BRK_OP if an interrupt is taken, else db_in.
//   - otherwise: T<=T<<1 (Ttwo->...->Tseven).
//   - Tseven with no last_cycle: hold Tseven (saturate). Watchdog variant under CONFIGURATION.
//  Interrupt take (evaluated at the Tone cycle edge only, with rdy=1):
//   - NMI if nmi_pend=1; else IRQ if irq_n=0 and status_i=0.
//   - Taken: activeInt<=010 or 001. NMI taken clears nmi_pend.
//   - Not taken: activeInt<=000. RESET (100) clears at the first fetch after its sequence.
//  nmi_pend: set when nmi_q=1 and nmi_n=0 at a cycle edge; nmi_q<=nmi_n every cycle edge.
//   If set and taken on the same edge, the take wins (pend ends 0).
//  sync = phi-independent: T==Tone.
//  Latency: opcode on db_in at Tone cycle edge is visible on OP at the next phi1 (1 clk).
// CONFIGURATION
//  TGEN_WATCHDOG_EN defined:
//   - Cycle edge in Tseven with last_cycle=0 and rdy=1 forces T<=Tone.
//   - t_err=1 for exactly the 2 clk of the following Tone cycle.
//  Not defined:
//   - T saturates at Tseven.
//   - t_err tied 0, no watchdog logic.
// STRUCTURE
//  Shared package/include (same one the control decoder uses): `Tone..`Tseven one-hot constants,
//   activeInt encodings (INT_NONE/IRQ/NMI/RST), BRK/NOP opcode constants.
//  One sub-module: int_arbiter (nmi edge detect, pending latch, priority select).
//   Phase toggle and T/IR registers stay in the top.
// TESTING
//  1 Reset release -> phi1 on first edge; T=Ttwo, OP=00, prevOP=EA, activeInt=100. last_cycle at T3 -> Tone,
//    db_in=A9 -> OP=A9, prevOP=00, activeInt=000.
//  2 Opcode 69 with last_cycle asserted in Ttwo -> T Tone,Ttwo alternating; at next fetch db_in=29 -> prevOP=69, OP=29.
//  3 rdy=0 for 3 cycles in Tthree -> T, OP, prevOP frozen; phi1/phi2 keep toggling; resume to Tfour.
//  4 irq_n=0, status_i=1 at fetch -> OP=db_in, activeInt=000. status_i=0 -> OP=00, activeInt=001.
//  5 nmi_n falls mid-instruction while irq_n=0 -> next fetch OP=00, activeInt=010.
//    nmi_n held low -> no second NMI.
//  6 TGEN_WATCHDOG_EN: no last_cycle through Tseven -> T=Tone, t_err high 2 clk.
//    Without the macro: T stays Tseven, t_err=0.
//    rst_n=0 mid-instruction in either build -> reset values on the next edge.

Source files
------------

// File: rtl/timing_generator_pkg.sv
// Shared constants for the timing generator and the control decoder:
// one-hot T-state codes, activeInt encodings and the opcodes the sequencer injects.
package timing_generator_pkg;

    localparam logic [6:0] Tone   = 7'b0000001;
    localparam logic [6:0] Ttwo   = 7'b0000010;
    localparam logic [6:0] Tthree = 7'b0000100;
    localparam logic [6:0] Tfour  = 7'b0001000;
    localparam logic [6:0] Tfive  = 7'b0010000;
    localparam logic [6:0] Tsix   = 7'b0100000;
    localparam logic [6:0] Tseven = 7'b1000000;

    typedef enum logic [2:0] {
        INT_NONE = 3'b000,
        INT_IRQ  = 3'b001,
        INT_NMI  = 3'b010,
        INT_RST  = 3'b100
    } intSel_t;

    localparam logic [7:0] OPC_BRK = 8'h00;
    localparam logic [7:0] OPC_NOP = 8'hEA;

endpackage

// File: rtl/timing_generator_int_arbiter.sv
// Interrupt arbiter: NMI falling-edge detect with pending latch, IRQ level gate,
// and the activeInt register that is updated only when an opcode is fetched.
module int_arbiter
    import timing_generator_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cycleEdge,
    input  logic       fetch,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       status_i,
    output logic       intTaken,
    output logic [2:0] activeInt
);

    logic    nmiQ;
    logic    nmiPend;
    logic    takeNmi;
    logic    takeIrq;
    intSel_t activeIntReg;

    assign takeNmi   = nmiPend;
    assign takeIrq   = ~nmiPend & ~irq_n & ~status_i;
    assign intTaken  = fetch & (takeNmi | takeIrq);
    assign activeInt = activeIntReg;

    // A take of an already pending NMI clears the latch even if a new edge arrives on the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nmiQ         <= 1'b1;
            nmiPend      <= 1'b0;
            activeIntReg <= INT_RST;
        end else begin
            if (cycleEdge) begin
                nmiQ <= nmi_n;
                if (fetch && takeNmi) begin
                    nmiPend <= 1'b0;
                end else if (nmiQ && !nmi_n) begin
                    nmiPend <= 1'b1;
                end
            end
            if (fetch) begin
                if (takeNmi) begin
                    activeIntReg <= INT_NMI;
                end else if (takeIrq) begin
                    activeIntReg <= INT_IRQ;
                end else begin
                    activeIntReg <= INT_NONE;
                end
            end
        end
    end

endmodule

// File: rtl/timing_generator.sv
// Two-phase clock generator, one-hot T-state sequencer and opcode latches.
// Optional macro TGEN_WATCHDOG_EN turns a stuck Tseven into a forced fetch with a t_err pulse.
module timing_generator
    import timing_generator_pkg::*;
#(
    parameter logic [7:0] NOP_OP = OPC_NOP,
    parameter logic [7:0] BRK_OP = OPC_BRK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] db_in,
    input  logic       rdy,
    input  logic       last_cycle,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       status_i,
    output logic       phi1,
    output logic       phi2,
    output logic [6:0] T,
    output logic [7:0] OP,
    output logic [7:0] prevOP,
    output logic [2:0] activeInt,
    output logic       sync,
    output logic       t_err
);

    logic       cycleEdge;
    logic       advance;
    logic       fetch;
    logic       intTaken;
    logic       watchdogFire;
    logic [6:0] tNext;
    logic [7:0] opNext;
    logic [7:0] prevOpNext;

    // The edge that ends phi2 closes a CPU cycle; every sequencing decision happens there.
    assign cycleEdge = phi2;
    assign advance   = cycleEdge & rdy;
    assign fetch     = advance & ~last_cycle & (T == Tone);
    assign sync      = (T == Tone);

`ifdef TGEN_WATCHDOG_EN
    logic tErrReg;

    assign watchdogFire = advance & ~last_cycle & (T == Tseven);
    assign t_err        = tErrReg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tErrReg <= 1'b0;
        end else if (cycleEdge) begin
            tErrReg <= watchdogFire;
        end
    end
`else
    assign watchdogFire = 1'b0;
    assign t_err        = 1'b0;
`endif

    int_arbiter uArbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .cycleEdge (cycleEdge),
        .fetch     (fetch),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .status_i  (status_i),
        .intTaken  (intTaken),
        .activeInt (activeInt)
    );

    // From the all-low reset state the first edge raises phi1, then the phases simply swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phi1 <= 1'b0;
            phi2 <= 1'b0;
        end else begin
            phi1 <= ~phi1;
            phi2 <= phi1;
        end
    end

    always_comb begin
        tNext      = T;
        opNext     = OP;
        prevOpNext = prevOP;
        if (advance) begin
            if (last_cycle) begin
                tNext = Tone;
            end else if (T == Tone) begin
                tNext      = Ttwo;
                prevOpNext = OP;
                opNext     = intTaken ? BRK_OP : db_in;
            end else if (T == Tseven) begin
                tNext = watchdogFire ? Tone : Tseven;
            end else begin
                tNext = {T[5:0], 1'b0};
            end
        end
    end

    // Reset lands in Ttwo with BRK loaded so the reset-vector sequence starts straight away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            T      <= Ttwo;
            OP     <= BRK_OP;
            prevOP <= NOP_OP;
        end else begin
            T      <= tNext;
            OP     <= opNext;
            prevOP <= prevOpNext;
        end
    end

endmodule

// File: tb/tb_timing_generator.sv
// Self-checking bench for timing_generator: directed scenarios then random stimulus,
// all checked every clock against a cycle-level behavioural model.
module tb_timing_generator;

    logic       clk;
    logic       rst_n;
    logic [7:0] db_in;
    logic       rdy;
    logic       last_cycle;
    logic       nmi_n;
    logic       irq_n;
    logic       status_i;
    logic       phi1;
    logic       phi2;
    logic [6:0] T;
    logic [7:0] OP;
    logic [7:0] prevOP;
    logic [2:0] activeInt;
    logic       sync;
    logic       t_err;

    int assertions = 0;
    int failures   = 0;

    // model state: edges since reset release, T as index 1..7, plain integers elsewhere
    int  mEdges;
    int  mTIdx;
    int  mOp;
    int  mPrevOp;
    int  mAct;
    bit  mNmiPend;
    bit  mNmiLast;
    bit  mTErr;
    bit  mCycDone;

    timing_generator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .db_in      (db_in),
        .rdy        (rdy),
        .last_cycle (last_cycle),
        .nmi_n      (nmi_n),
        .irq_n      (irq_n),
        .status_i   (status_i),
        .phi1       (phi1),
        .phi2       (phi2),
        .T          (T),
        .OP         (OP),
        .prevOP     (prevOP),
        .activeInt  (activeInt),
        .sync       (sync),
        .t_err      (t_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rstN, input bit rdyV, input bit lastV, input logic [7:0] db,
                                 input bit nmiN, input bit irqN, input bit statusV);
        rst_n      = rstN;
        rdy        = rdyV;
        last_cycle = lastV;
        db_in      = db;
        nmi_n      = nmiN;
        irq_n      = irqN;
        status_i   = statusV;
    endtask

    // One clock edge of the behavioural model, driven only by the bench's own inputs.
    task automatic modelEdge();
        bit cyc;
        bit fell;
        bit tookNmi;
        bit wd;
        mCycDone = 1'b0;
        if (!rst_n) begin
            mEdges   = 0;
            mTIdx    = 2;
            mOp      = 'h00;
            mPrevOp  = 'hEA;
            mAct     = 4;
            mNmiPend = 1'b0;
            mNmiLast = 1'b1;
            mTErr    = 1'b0;
            return;
        end
        cyc = (mEdges > 0) && (mEdges % 2 == 0);
        mEdges++;
        if (!cyc) return;
        mCycDone = 1'b1;
        fell     = mNmiLast && !nmi_n;
        mNmiLast = nmi_n;
        tookNmi  = 1'b0;
        wd       = 1'b0;
        if (rdy) begin
            if (last_cycle) begin
                mTIdx = 1;
            end else if (mTIdx == 1) begin
                mPrevOp = mOp;
                if (mNmiPend) begin
                    mAct = 2; mOp = 'h00; tookNmi = 1'b1;
                end else if (!irq_n && !status_i) begin
                    mAct = 1; mOp = 'h00;
                end else begin
                    mAct = 0; mOp = int'(db_in);
                end
                mTIdx = 2;
            end else if (mTIdx == 7) begin
`ifdef TGEN_WATCHDOG_EN
                mTIdx = 1;
                wd    = 1'b1;
`endif
            end else begin
                mTIdx++;
            end
        end
        mNmiPend = tookNmi ? 1'b0 : (mNmiPend | fell);
        mTErr    = wd;
    endtask

    task automatic compareAll();
        checkOutput("phi1", phi1, (mEdges % 2 == 1));
        checkOutput("phi2", phi2, (mEdges > 0) && (mEdges % 2 == 0));
        checkOutput("T", T, 32'(1 << (mTIdx - 1)));
        checkOutput("OP", OP, mOp);
        checkOutput("prevOP", prevOP, mPrevOp);
        checkOutput("activeInt", activeInt, mAct);
        checkOutput("sync", sync, (mTIdx == 1));
        checkOutput("t_err", t_err, mTErr);
    endtask

    task automatic stepClk();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
        @(negedge clk);
    endtask

    // Runs clocks until the model has closed one CPU cycle (at most 4 clocks).
    task automatic cpuCycle();
        for (int i = 0; i < 4; i++) begin
            stepClk();
            if (mCycDone) break;
        end
    endtask

    initial begin
        applyStimulus(0, 1, 0, 8'h00, 1, 1, 1);
        repeat (2) stepClk();
        checkOutput("rst_T", T, 7'b0000010);
        checkOutput("rst_OP", OP, 8'h00);
        checkOutput("rst_prevOP", prevOP, 8'hEA);
        checkOutput("rst_act", activeInt, 3'b100);
        checkOutput("rst_phi", {phi1, phi2}, 2'b00);

        // reset release, reset sequence ends at T3, fetch A9
        applyStimulus(1, 1, 0, 8'h00, 1, 1, 1);
        stepClk();
        checkOutput("s1_phi1_first", phi1, 1'b1);
        cpuCycle();
        checkOutput("s1_T3", T, 7'b0000100);
        applyStimulus(1, 1, 1, 8'h00, 1, 1, 1);
        cpuCycle();
        checkOutput("s1_sync", sync, 1'b1);
        applyStimulus(1, 1, 0, 8'hA9, 1, 1, 1);
        cpuCycle();
        checkOutput("s1_OP", OP, 8'hA9);
        checkOutput("s1_prevOP", prevOP, 8'h00);
        checkOutput("s1_act", activeInt, 3'b000);
        checkOutput("s1_phi1", phi1, 1'b1);

        // two-cycle instructions 69 then 29
        applyStimulus(1, 1, 1, 8'h00, 1, 1, 1); cpuCycle();
        applyStimulus(1, 1, 0, 8'h69, 1, 1, 1); cpuCycle();
        applyStimulus(1, 1, 1, 8'h00, 1, 1, 1); cpuCycle();
        checkOutput("s2_Tone", T, 7'b0000001);
        applyStimulus(1, 1, 0, 8'h29, 1, 1, 1); cpuCycle();
        checkOutput("s2_OP", OP, 8'h29);
        checkOutput("s2_prevOP", prevOP, 8'h69);

        // rdy stall in T3
        cpuCycle();
        applyStimulus(1, 0, 1, 8'h55, 1, 1, 1);
        repeat (3) cpuCycle();
        checkOutput("s3_hold_T", T, 7'b0000100);
        applyStimulus(1, 1, 0, 8'h55, 1, 1, 1); cpuCycle();
        checkOutput("s3_resume_T", T, 7'b0001000);

        // IRQ masked, then taken
        applyStimulus(1, 1, 1, 8'h00, 1, 0, 1); cpuCycle();
        applyStimulus(1, 1, 0, 8'h4C, 1, 0, 1); cpuCycle();
        checkOutput("s4_masked_OP", OP, 8'h4C);
        checkOutput("s4_masked_act", activeInt, 3'b000);
        applyStimulus(1, 1, 1, 8'h00, 1, 0, 0); cpuCycle();
        applyStimulus(1, 1, 0, 8'h4C, 1, 0, 0); cpuCycle();
        checkOutput("s4_irq_OP", OP, 8'h00);
        checkOutput("s4_irq_act", activeInt, 3'b001);

        // NMI beats IRQ, held-low NMI does not retrigger
        applyStimulus(1, 1, 0, 8'h4C, 0, 0, 0); cpuCycle();
        applyStimulus(1, 1, 1, 8'h4C, 0, 0, 0); cpuCycle();
        applyStimulus(1, 1, 0, 8'h4C, 0, 0, 0); cpuCycle();
        checkOutput("s5_nmi_OP", OP, 8'h00);
        checkOutput("s5_nmi_act", activeInt, 3'b010);
        applyStimulus(1, 1, 1, 8'h4C, 0, 0, 0); cpuCycle();
        applyStimulus(1, 1, 0, 8'h4C, 0, 0, 0); cpuCycle();
        checkOutput("s5_no_renmi", activeInt, 3'b001);

        // run off the end of the T sequence
        applyStimulus(1, 1, 0, 8'h11, 1, 1, 1);
        repeat (5) cpuCycle();
        checkOutput("s6_T7", T, 7'b1000000);
        cpuCycle();
`ifdef TGEN_WATCHDOG_EN
        checkOutput("s6_wd_T", T, 7'b0000001);
        checkOutput("s6_wd_err", t_err, 1'b1);
        stepClk();
        checkOutput("s6_wd_err_2nd", t_err, 1'b1);
`else
        checkOutput("s6_sat_T", T, 7'b1000000);
        checkOutput("s6_sat_err", t_err, 1'b0);
`endif
        cpuCycle();

        // mid-instruction reset
        applyStimulus(0, 1, 0, 8'h11, 0, 0, 0);
        stepClk();
        checkOutput("s6_rst_T", T, 7'b0000010);
        checkOutput("s6_rst_OP", OP, 8'h00);
        checkOutput("s6_rst_prevOP", prevOP, 8'hEA);
        checkOutput("s6_rst_act", activeInt, 3'b100);

        // random traffic
        applyStimulus(1, 1, 0, 8'h00, 1, 1, 1);
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 5) != 0),
                          (mTIdx != 1) && ($urandom_range(0, 3) == 0),
                          8'($urandom),
                          ($urandom_range(0, 9) == 0) ? ~nmi_n : nmi_n,
                          ($urandom_range(0, 3) != 0),
                          1'($urandom));
            stepClk();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
